// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a req/gnt/rvalid data-memory port, aligns
// and extends load data, stalls upstream while an access is outstanding, and owns MEM/WB.
module mem_stage #(
  parameter int WIDTH    = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic [WIDTH-1:0]    alu_out_i,
  input  logic [WIDTH-1:0]    rs2_data_i,
  input  logic                mem_rd_i,
  input  logic                mem_wr_i,
  input  logic [2:0]          mem_op_i,
  input  logic [4:0]          rd_addr_i,
  input  logic                rf_w_en_i,
  input  logic [1:0]          wbsel_i,
  output logic                stall_o,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [WIDTH-1:0]    dmem_wdata,
  output logic [3:0]          dmem_wstrb,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [WIDTH-1:0]    dmem_rdata,
  output logic                valid_o,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [WIDTH-1:0]    alu_out_o,
  output logic [WIDTH-1:0]    mem_data_o,
  output logic [4:0]          rd_addr_o,
  output logic                rf_w_en_o,
  output logic [1:0]          wbsel_o,
  output logic                misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t     state, state_next;
  logic       mem_op, is_store, is_byte, is_half, is_word;
  logic       misalign, access;
  logic [1:0] byte_off;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_ext;

  // A request with both read and write set is a store.
  assign mem_op   = valid_i & (mem_rd_i | mem_wr_i);
  assign is_store = mem_wr_i;
  assign byte_off = alu_out_i[1:0];
  assign is_byte  = (mem_op_i[1:0] == 2'b00);
  assign is_half  = (mem_op_i[1:0] == 2'b01);
  assign is_word  = ~is_byte & ~is_half;
  assign misalign = mem_op & ((is_half & byte_off[0]) | (is_word & (byte_off != 2'b00)));
  assign access   = mem_op & ~misalign;

  assign dmem_addr = {alu_out_i[ADDR_LEN-1:2], 2'b00};
  assign dmem_we   = dmem_req & is_store;

  always_comb begin
    dmem_wdata = rs2_data_i;
    dmem_wstrb = 4'b0000;
    if (is_byte) begin
      dmem_wdata = {4{rs2_data_i[7:0]}};
      dmem_wstrb = 4'b0001 << byte_off;
    end else if (is_half) begin
      dmem_wdata = {2{rs2_data_i[15:0]}};
      dmem_wstrb = 4'b0011 << byte_off;
    end else begin
      dmem_wstrb = 4'b1111;
    end
    if (!is_store) dmem_wstrb = 4'b0000;
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (byte_off)
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = byte_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (mem_op_i)
      3'b000:  ld_ext = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {{(WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_ext = {{(WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {{(WIDTH-16){1'b0}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    dmem_req   = 1'b0;
    stall_o    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          dmem_req = 1'b1;
          if (!dmem_gnt) begin
            stall_o    = 1'b1;
            state_next = REQ;
          end else if (!is_store) begin
            stall_o    = 1'b1;
            state_next = WAIT;
          end
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        if (!dmem_gnt) begin
          stall_o = 1'b1;
        end else if (is_store) begin
          state_next = IDLE;
        end else begin
          stall_o    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (dmem_rvalid) state_next = IDLE;
        else             stall_o    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Reset must silence the port even while upstream still presents a memory op.
    if (!reset) begin
      dmem_req = 1'b0;
      stall_o  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      valid_o    <= 1'b0;
      pc_o       <= '0;
      alu_out_o  <= '0;
      mem_data_o <= '0;
      rd_addr_o  <= '0;
      rf_w_en_o  <= 1'b0;
      wbsel_o    <= '0;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_next;
      valid_o    <= valid_i & ~stall_o;
      pc_o       <= pc_i;
      alu_out_o  <= alu_out_i;
      mem_data_o <= (state == WAIT && dmem_rvalid) ? ld_ext : '0;
      rd_addr_o  <= rd_addr_i;
      rf_w_en_o  <= valid_i & rf_w_en_i & ~misalign & ~stall_o;
      wbsel_o    <= wbsel_i;
      misalign_o <= misalign & ~stall_o;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a scoreboard queue holds the MEM/WB slot each
// instruction should produce and a monitor pops it whenever valid_o rises.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i, mem_rd_i, mem_wr_i, rf_w_en_i;
  logic [31:0] pc_i, alu_out_i, rs2_data_i;
  logic [2:0]  mem_op_i;
  logic [4:0]  rd_addr_i;
  logic [1:0]  wbsel_i;
  logic        stall_o, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        valid_o, rf_w_en_o, misalign_o;
  logic [31:0] pc_o, alu_out_o, mem_data_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  wbsel_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        rf_w_en;
    logic [1:0]  wbsel;
    logic        misalign;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_exp;
  int   checks = 0;
  int   errors = 0;

  mem_stage #(.WIDTH(32), .ADDR_LEN(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i), .alu_out_i(alu_out_i),
    .rs2_data_i(rs2_data_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_op_i(mem_op_i),
    .rd_addr_i(rd_addr_i), .rf_w_en_i(rf_w_en_i), .wbsel_i(wbsel_i), .stall_o(stall_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .valid_o(valid_o), .pc_o(pc_o), .alu_out_o(alu_out_o),
    .mem_data_o(mem_data_o), .rd_addr_o(rd_addr_o), .rf_w_en_o(rf_w_en_o),
    .wbsel_o(wbsel_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; pc_i = '0; alu_out_i = '0; rs2_data_i = '0;
    mem_rd_i = 1'b0; mem_wr_i = 1'b0; mem_op_i = 3'b010;
    rd_addr_i = '0; rf_w_en_i = 1'b0; wbsel_i = '0;
  endtask

  task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                                input logic rd_en, input logic wr_en, input logic [2:0] op,
                                input logic [4:0] rd, input logic rf, input logic [1:0] wb);
    valid_i = 1'b1; pc_i = pc; alu_out_i = alu; rs2_data_i = rs2;
    mem_rd_i = rd_en; mem_wr_i = wr_en; mem_op_i = op;
    rd_addr_i = rd; rf_w_en_i = rf; wbsel_i = wb;
  endtask

  task automatic push_expect(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] data,
                             input logic chk, input logic [4:0] rd, input logic rf,
                             input logic [1:0] wb, input logic mis);
    exp_t e;
    e.pc = pc; e.alu = alu; e.data = data; e.chk_data = chk;
    e.rd = rd; e.rf_w_en = rf; e.wbsel = wb; e.misalign = mis;
    sb_q.push_back(e);
  endtask

  // Every retiring MEM/WB slot must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset && valid_o) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid: observed valid_o=1 expected no pending instruction");
      end
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        check_output("wb_pc", pc_o, mon_exp.pc);
        check_output("wb_alu", alu_out_o, mon_exp.alu);
        check_output("wb_rd", 32'(rd_addr_o), 32'(mon_exp.rd));
        check_output("wb_rf_w_en", 32'(rf_w_en_o), 32'(mon_exp.rf_w_en));
        check_output("wb_wbsel", 32'(wbsel_o), 32'(mon_exp.wbsel));
        check_output("wb_misalign", 32'(misalign_o), 32'(mon_exp.misalign));
        if (mon_exp.chk_data) check_output("wb_mem_data", mem_data_o, mon_exp.data);
      end
    end
  end

  task automatic run_store(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [2:0] op, input int gnt_delay,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    apply_stimulus(pc, addr, rs2, 1'b0, 1'b1, op, 5'd0, 1'b0, 2'd0);
    push_expect(pc, addr, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    for (int c = 0; c <= gnt_delay; c++) begin
      dmem_gnt = (c == gnt_delay);
      @(negedge clk);
      check_output({tag, "_req"}, 32'(dmem_req), 32'd1);
      check_output({tag, "_we"}, 32'(dmem_we), 32'd1);
      check_output({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
      check_output({tag, "_wstrb"}, 32'(dmem_wstrb), 32'(exp_strb));
      check_output({tag, "_wdata"}, dmem_wdata, exp_wdata);
      check_output({tag, "_stall"}, 32'(stall_o), 32'(c != gnt_delay));
      check_output({tag, "_bubble"}, 32'(valid_o), 32'd0);
      next_cycle();
    end
    dmem_gnt = 1'b0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic run_load(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                          input logic [2:0] op, input logic [31:0] rdata, input int gnt_delay,
                          input int rv_delay, input logic [31:0] exp_data, input logic [4:0] rd);
    int last;
    last = gnt_delay + rv_delay;
    apply_stimulus(pc, addr, 32'h0, 1'b1, 1'b0, op, rd, 1'b1, 2'd1);
    push_expect(pc, addr, exp_data, 1'b1, rd, 1'b1, 2'd1, 1'b0);
    for (int c = 0; c <= last; c++) begin
      dmem_gnt    = (c == gnt_delay);
      dmem_rvalid = (c == last);
      dmem_rdata  = (c == last) ? rdata : 32'h0;
      @(negedge clk);
      check_output({tag, "_req"}, 32'(dmem_req), 32'(c <= gnt_delay));
      check_output({tag, "_stall"}, 32'(stall_o), 32'(c != last));
      check_output({tag, "_bubble"}, 32'(valid_o), 32'd0);
      if (c == 0) begin
        check_output({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check_output({tag, "_we"}, 32'(dmem_we), 32'd0);
        check_output({tag, "_wstrb"}, 32'(dmem_wstrb), 32'd0);
      end
      next_cycle();
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic run_alu(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd);
    apply_stimulus(pc, alu, 32'h0, 1'b0, 1'b0, 3'b010, rd, 1'b1, 2'd0);
    push_expect(pc, alu, 32'h0, 1'b0, rd, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    check_output("alu_req", 32'(dmem_req), 32'd0);
    check_output("alu_stall", 32'(stall_o), 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_output("alu_req_after", 32'(dmem_req), 32'd0);
    next_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_valid"}, 32'(valid_o), 32'd0);
    check_output({tag, "_pc"}, pc_o, 32'd0);
    check_output({tag, "_alu"}, alu_out_o, 32'd0);
    check_output({tag, "_mem_data"}, mem_data_o, 32'd0);
    check_output({tag, "_rd"}, 32'(rd_addr_o), 32'd0);
    check_output({tag, "_rf_w_en"}, 32'(rf_w_en_o), 32'd0);
    check_output({tag, "_wbsel"}, 32'(wbsel_o), 32'd0);
    check_output({tag, "_misalign"}, 32'(misalign_o), 32'd0);
    check_output({tag, "_req"}, 32'(dmem_req), 32'd0);
    check_output({tag, "_stall"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    idle_inputs();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_init");
    reset = 1'b1;
    next_cycle();

    run_alu(32'h0000_0010, 32'h0000_1234, 5'd5);

    // A bubble slot with rf_w_en and mem_rd set must neither access memory nor write back.
    valid_i = 1'b0; rf_w_en_i = 1'b1; mem_rd_i = 1'b1; alu_out_i = 32'h0000_0200;
    @(negedge clk);
    check_output("bubble_req", 32'(dmem_req), 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_output("bubble_valid", 32'(valid_o), 32'd0);
    check_output("bubble_rf_w_en", 32'(rf_w_en_o), 32'd0);
    next_cycle();

    run_store("sb", 32'h0000_0020, 32'h0000_0103, 32'h0000_00AB, 3'b000, 0, 4'b1000, 32'hABAB_ABAB);
    run_store("sh", 32'h0000_0024, 32'h0000_0106, 32'h1234_ABCD, 3'b001, 1, 4'b1100, 32'hABCD_ABCD);
    run_store("sw", 32'h0000_0028, 32'h0000_0108, 32'hCAFE_F00D, 3'b010, 0, 4'b1111, 32'hCAFE_F00D);

    run_load("lb",  32'h0000_0030, 32'h0000_0202, 3'b000, 32'h12F4_5678, 2, 3, 32'hFFFF_FFF4, 5'd7);
    run_load("lbu", 32'h0000_0034, 32'h0000_0202, 3'b100, 32'h12F4_5678, 2, 3, 32'h0000_00F4, 5'd8);
    run_load("lh",  32'h0000_0038, 32'h0000_0302, 3'b001, 32'h8001_FFFF, 0, 1, 32'hFFFF_8001, 5'd9);
    run_load("lhu", 32'h0000_003C, 32'h0000_0302, 3'b101, 32'h8001_FFFF, 0, 1, 32'h0000_8001, 5'd10);
    run_load("lw",  32'h0000_0040, 32'h0000_0300, 3'b010, 32'h8001_FFFF, 1, 2, 32'h8001_FFFF, 5'd11);

    // Misaligned word load: no request, single cycle, flagged slot without writeback.
    apply_stimulus(32'h0000_0060, 32'h0000_0401, 32'h0, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1, 2'd1);
    push_expect(32'h0000_0060, 32'h0000_0401, 32'h0, 1'b0, 5'd9, 1'b0, 2'd1, 1'b1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    check_output("mis_lw_req", 32'(dmem_req), 32'd0);
    check_output("mis_lw_stall", 32'(stall_o), 32'd0);
    next_cycle();
    dmem_gnt = 1'b0;
    apply_stimulus(32'h0000_0064, 32'h0000_0402, 32'h1111_2222, 1'b0, 1'b1, 3'b010, 5'd0, 1'b0, 2'd0);
    push_expect(32'h0000_0064, 32'h0000_0402, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    check_output("mis_sw_req", 32'(dmem_req), 32'd0);
    check_output("mis_sw_stall", 32'(stall_o), 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Reset while a load sits in WAIT; the late rvalid must be ignored.
    apply_stimulus(32'h0000_0070, 32'h0000_0500, 32'h0, 1'b1, 1'b0, 3'b010, 5'd3, 1'b1, 2'd1);
    push_expect(32'h0000_0070, 32'h0000_0500, 32'h0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    check_output("rst_wait_req", 32'(dmem_req), 32'd1);
    check_output("rst_wait_stall", 32'(stall_o), 32'd1);
    next_cycle();
    dmem_gnt = 1'b0;
    @(negedge clk);
    check_output("rst_wait_stall2", 32'(stall_o), 32'd1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("reset_mid");
    void'(sb_q.pop_back());
    idle_inputs();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_output("late_rvalid_stall", 32'(stall_o), 32'd0);
    check_output("late_rvalid_req", 32'(dmem_req), 32'd0);
    next_cycle();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    check_output("late_rvalid_valid", 32'(valid_o), 32'd0);
    next_cycle();

    run_alu(32'h0000_0080, 32'h0000_5678, 5'd12);

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
